// File: rtl/modulation_buffer_writer.sv
// ---------------------------------------------------------------------------
// modulation_buffer_writer
//
// Writer side of the double-banked modulation sample RAM. A framed byte
// stream is written into the bank the sampler is NOT reading. Once the frame
// ends, the new buffer is committed atomically at the next sampler wrap.
// The commit toggles ACTIVE_BANK and loads MOD_CYCLE in the same cycle, so
// playback never mixes old and new samples.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   S_START         pulse: begin (or restart) a frame
//   S_VALID/S_READY sample handshake; S_DATA payload, S_LAST marks final beat
//   SAMPLER_WRAP    sampler playback wrap point (commit opportunity)
//   BRAM_WE/ADDR/DIN registered write port, ADDR = {bank, sample index}
//   ACTIVE_BANK     bank the sampler reads
//   MOD_CYCLE       last valid sample index of the active bank
//   BUSY            frame loading or waiting for commit
//   ERR_OVERFLOW    sticky: frame exceeded bank capacity (cleared on START)
// ---------------------------------------------------------------------------
module modulation_buffer_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S_START,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    input  logic                  S_LAST,
    input  logic                  SAMPLER_WRAP,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH:0]   BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DIN,
    output logic                  ACTIVE_BANK,
    output logic [15:0]           MOD_CYCLE,
    output logic                  BUSY,
    output logic                  ERR_OVERFLOW
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] pending_cycle;
    // Set once the last slot of the bank has been written. From then on idx
    // stays saturated at all-ones and further beats are dropped.
    logic                  full;

    assign S_READY = (state == ST_LOAD);
    assign BUSY    = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            idx           <= '0;
            full          <= 1'b0;
            pending_cycle <= '0;
            BRAM_WE       <= 1'b0;
            BRAM_ADDR     <= '0;
            BRAM_DIN      <= '0;
            ACTIVE_BANK   <= 1'b0;
            MOD_CYCLE     <= '0;
            ERR_OVERFLOW  <= 1'b0;
        end else begin
            BRAM_WE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (S_START) begin
                        state        <= ST_LOAD;
                        idx          <= '0;
                        full         <= 1'b0;
                        ERR_OVERFLOW <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (S_START) begin
                        // Restart: any beat in this cycle belongs to the
                        // abandoned frame and is ignored.
                        idx          <= '0;
                        full         <= 1'b0;
                        ERR_OVERFLOW <= 1'b0;
                    end else if (S_VALID) begin
                        if (!full) begin
                            BRAM_WE   <= 1'b1;
                            BRAM_ADDR <= {~ACTIVE_BANK, idx};
                            BRAM_DIN  <= S_DATA;
                            if (&idx) full <= 1'b1;
                            else      idx  <= idx + 1'b1;
                        end else begin
                            ERR_OVERFLOW <= 1'b1;
                        end
                        // When overflowing, idx is saturated, so the
                        // committed cycle length is the full bank.
                        if (S_LAST) begin
                            pending_cycle <= idx;
                            state         <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // Only reached the cycle after the last beat, so the
                    // final BRAM write lands before (or with) the swap.
                    if (SAMPLER_WRAP) begin
                        ACTIVE_BANK <= ~ACTIVE_BANK;
                        MOD_CYCLE   <= 16'(pending_cycle);
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modulation_buffer_writer.sv
module tb_modulation_buffer_writer;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST, S_START, S_VALID, S_LAST, SAMPLER_WRAP;
    logic [DW-1:0] S_DATA;
    logic          S_READY, BRAM_WE, ACTIVE_BANK, BUSY, ERR_OVERFLOW;
    logic [AW:0]   BRAM_ADDR;
    logic [DW-1:0] BRAM_DIN;
    logic [15:0]   MOD_CYCLE;

    modulation_buffer_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .S_START(S_START), .S_VALID(S_VALID),
        .S_READY(S_READY), .S_DATA(S_DATA), .S_LAST(S_LAST),
        .SAMPLER_WRAP(SAMPLER_WRAP), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
        .BRAM_DIN(BRAM_DIN), .ACTIVE_BANK(ACTIVE_BANK), .MOD_CYCLE(MOD_CYCLE),
        .BUSY(BUSY), .ERR_OVERFLOW(ERR_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame phase (0 idle, 1 loading, 2 awaiting commit),
    // unbounded beat count of the current frame and the expected write.
    int            m_mode, m_cnt, m_pend;
    logic          m_bank, m_err, m_we;
    logic [AW:0]   m_addr;
    logic [DW-1:0] m_din;
    logic [15:0]   m_mc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, clock, check everything.
    task automatic cyc(input logic st, input logic v, input logic [DW-1:0] d,
                       input logic l, input logic w, input logic r);
        S_START = st; S_VALID = v; S_DATA = d; S_LAST = l; SAMPLER_WRAP = w; RST = r;
        m_we = 1'b0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_pend = 0; m_bank = 0; m_err = 0;
            m_addr = '0; m_din = '0; m_mc = '0;
        end else begin
            case (m_mode)
                0: if (st) begin m_mode = 1; m_cnt = 0; m_err = 0; end
                1: begin
                    if (st) begin
                        m_cnt = 0; m_err = 0;
                    end else if (v) begin
                        if (m_cnt < DEPTH) begin
                            m_we = 1'b1;
                            m_addr = {~m_bank, AW'(m_cnt)};
                            m_din = d;
                        end else begin
                            m_err = 1'b1;
                        end
                        if (l) begin
                            m_pend = (m_cnt < DEPTH) ? m_cnt : DEPTH - 1;
                            m_mode = 2;
                        end
                        m_cnt++;
                    end
                end
                default: if (w) begin m_bank = ~m_bank; m_mc = 16'(m_pend); m_mode = 0; end
            endcase
        end
        @(posedge CLK);
        #1;
        chk("outs{rdy,we,busy,bank,err,mc}",
            {S_READY, BRAM_WE, BUSY, ACTIVE_BANK, ERR_OVERFLOW, MOD_CYCLE},
            {m_mode == 1, m_we, m_mode != 0, m_bank, m_err, m_mc});
        if (m_we || r) chk("wr{addr,din}", {BRAM_ADDR, BRAM_DIN}, {m_addr, m_din});
    endtask

    task automatic idle_cyc(input logic w);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, w, 1'b0);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        cyc(1'b0, 1'b1, d, l, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic          st, v;
        logic [DW-1:0] d;
        logic          l, w;
        logic          we;
        logic [AW:0]   addr;
        logic [DW-1:0] din;
        logic          rdy, busy, bank;
        logic [15:0]   mc;
    } vec_t;

    vec_t tbl[8];
    int   nwr;

    initial begin
        // Test 1 expectations written out from the frame rules.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 17'h10000, 8'h10, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 17'h10001, 8'h20, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 17'h10002, 8'h30, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 17'h10003, 8'h40, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 16'd3};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 16'd3};

        S_START = 0; S_VALID = 0; S_DATA = 0; S_LAST = 0; SAMPLER_WRAP = 0; RST = 1;
        cyc(0, 0, 8'h00, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 1);
        chk("reset_state",
            {S_READY, BRAM_WE, BRAM_ADDR, BRAM_DIN, ACTIVE_BANK, MOD_CYCLE, BUSY, ERR_OVERFLOW}, 64'd0);
        idle_cyc(1'b1);   // wrap while idle is ignored

        // Test 1: table-driven frame of four beats into bank 1
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].w, 1'b0);
            chk($sformatf("t1[%0d].we", i), BRAM_WE, tbl[i].we);
            if (tbl[i].we) chk($sformatf("t1[%0d].wr", i), {BRAM_ADDR, BRAM_DIN}, {tbl[i].addr, tbl[i].din});
            chk($sformatf("t1[%0d].st", i), {S_READY, BUSY, ACTIVE_BANK, MOD_CYCLE},
                {tbl[i].rdy, tbl[i].busy, tbl[i].bank, tbl[i].mc});
        end

        // Test 2: two beats go to bank 0
        cyc(1, 0, 8'h00, 0, 0, 0);
        beat(8'h55, 0);
        chk("t2_addr0", BRAM_ADDR, 17'h00000);
        beat(8'h66, 1);
        chk("t2_addr1", BRAM_ADDR, 17'h00001);
        idle_cyc(0);
        idle_cyc(1);
        chk("t2_commit", {ACTIVE_BANK, MOD_CYCLE}, {1'b0, 16'd1});

        // Test 3: restart mid-frame, then a single-beat frame
        cyc(1, 0, 8'h00, 0, 0, 0);
        beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0);
        cyc(1, 1, 8'h77, 0, 0, 0);
        chk("t3_restart_beat_ignored", BRAM_WE, 1'b0);
        beat(8'hAA, 1);
        chk("t3_single_write", {BRAM_WE, BRAM_ADDR, BRAM_DIN}, {1'b1, 17'h10000, 8'hAA});
        idle_cyc(1);
        chk("t3_commit", {ACTIVE_BANK, MOD_CYCLE}, {1'b1, 16'd0});

        // Test 5: wrap with the last beat is not used; valid and start in PENDING ignored
        cyc(1, 0, 8'h00, 0, 0, 0);
        beat(8'hC1, 0);
        cyc(0, 1, 8'hC2, 1, 1, 0);
        chk("t5_no_early_swap", {BUSY, ACTIVE_BANK}, {1'b1, 1'b1});
        cyc(0, 1, 8'hC3, 0, 0, 0);
        chk("t5_pend_no_ready", {S_READY, BRAM_WE}, 2'b00);
        cyc(1, 1, 8'hC4, 1, 0, 0);
        chk("t5_start_in_pend", {S_READY, BRAM_WE, BUSY}, 3'b001);
        idle_cyc(1);
        chk("t5_commit", {ACTIVE_BANK, MOD_CYCLE, BUSY}, {1'b0, 16'd1, 1'b0});

        // Test 6: reset during LOAD and during PENDING, then a clean frame
        cyc(1, 0, 8'h00, 0, 0, 0);
        beat(8'h11, 0); beat(8'h12, 0);
        cyc(0, 1, 8'h13, 0, 1, 1);
        chk("t6_rst_load",
            {S_READY, BRAM_WE, BRAM_ADDR, BRAM_DIN, ACTIVE_BANK, MOD_CYCLE, BUSY, ERR_OVERFLOW}, 64'd0);
        cyc(1, 0, 8'h00, 0, 0, 0);
        beat(8'h21, 0); beat(8'h22, 1);
        cyc(0, 0, 8'h00, 0, 1, 1);
        chk("t6_rst_pend",
            {S_READY, BRAM_WE, BRAM_ADDR, BRAM_DIN, ACTIVE_BANK, MOD_CYCLE, BUSY, ERR_OVERFLOW}, 64'd0);
        idle_cyc(1);
        cyc(1, 0, 8'h00, 0, 0, 0);
        beat(8'h31, 0);
        chk("t6_bank1_addr", BRAM_ADDR, 17'h10000);
        beat(8'h32, 0); beat(8'h33, 1);
        idle_cyc(1);
        chk("t6_commit", {ACTIVE_BANK, MOD_CYCLE}, {1'b1, 16'd2});

        // Test 4: overflow, 65537 beats into bank 0
        nwr = 0;
        cyc(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i <= DEPTH; i++) begin
            beat(8'(i), i == DEPTH);
            if (BRAM_WE) nwr++;
        end
        chk("t4_write_count", nwr, DEPTH);
        chk("t4_err", ERR_OVERFLOW, 1'b1);
        idle_cyc(1);
        chk("t4_commit", {ACTIVE_BANK, MOD_CYCLE, ERR_OVERFLOW}, {1'b0, 16'hFFFF, 1'b1});
        cyc(1, 0, 8'h00, 0, 0, 0);
        chk("t4_err_clear", ERR_OVERFLOW, 1'b0);
        beat(8'h9, 1);
        idle_cyc(1);

        // Randomized frames checked against the model
        for (int f = 0; f < 40; f++) begin
            int len;
            int k;
            len = $urandom_range(1, 24);
            for (int g = $urandom_range(0, 3); g > 0; g--) idle_cyc($urandom_range(0, 1));
            cyc(1, $urandom_range(0, 1), 8'($urandom), 0, 0, 0);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 15) == 0) cyc(1, $urandom_range(0, 1), 8'($urandom), 0, 0, 0);
                while ($urandom_range(0, 3) == 0) cyc(0, 0, 8'($urandom), 0, $urandom_range(0, 1), 0);
                cyc(0, 1, 8'($urandom), b == len - 1, $urandom_range(0, 1), 0);
            end
            k = 0;
            while (m_mode == 2 && k < 50) begin
                cyc($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                    $urandom_range(0, 3) == 0, 0);
                k++;
            end
            if (m_mode == 2) idle_cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modulation_buffer_writer.md
Name: modulation_buffer_writer

Overview:
Writer side of the modulation sample RAM that the modulation sampler reads. It accepts a framed byte stream of modulation samples from the CPU-side bus and writes them into the inactive half of a double-banked modulation BRAM. It commits the new buffer atomically by swapping ACTIVE_BANK and MOD_CYCLE only at a sampler wrap, so playback never mixes old and new samples.

Parameters:
ADDR_WIDTH, 16, sample address width per bank; a bank holds 2^ADDR_WIDTH samples.
DATA_WIDTH, 8, modulation sample width.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-high reset
S_START  input  1  pulse; begins a new frame
S_VALID  input  1  sample byte valid
S_READY  output  1  writer accepts a sample this cycle
S_DATA  input  DATA_WIDTH  sample value
S_LAST  input  1  qualifies the final sample of a frame (with S_VALID && S_READY)
SAMPLER_WRAP  input  1  sampler's UPDATE while its ADDR == MOD_CYCLE (playback wrap point)
BRAM_WE  output  1  write strobe to modulation BRAM
BRAM_ADDR  output  ADDR_WIDTH+1  {bank, sample index}
BRAM_DIN  output  DATA_WIDTH  write data
ACTIVE_BANK  output  1  bank the sampler reads
MOD_CYCLE  output  16  last valid sample index of the active bank (count-1)
BUSY  output  1  high in LOAD or PENDING
ERR_OVERFLOW  output  1  sticky; frame exceeded bank capacity

Behaviour:
- Reset: state IDLE; S_READY=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0, ACTIVE_BANK=0, MOD_CYCLE=0, BUSY=0, ERR_OVERFLOW=0; write index=0. Reset applies mid-frame and mid-PENDING; partial data is abandoned and no swap occurs.
- IDLE: S_READY=0. When S_START=1, go to LOAD next cycle, clear the write index, and clear ERR_OVERFLOW.
- LOAD: S_READY=1. A beat is accepted when S_VALID && S_READY.
  - On each accepted beat, the next cycle drives BRAM_WE=1, BRAM_ADDR={~ACTIVE_BANK, idx}, BRAM_DIN=S_DATA. This gives 1-cycle registered write latency.
  - idx increments by 1 after each accepted beat.
- Overflow:
  - A beat accepted when idx has already written 2^ADDR_WIDTH samples is dropped: no BRAM_WE.
  - Dropping a beat sets ERR_OVERFLOW, and idx saturates at all-ones.
  - The resulting frame commits with MOD_CYCLE = 2^ADDR_WIDTH - 1 (0xFFFF at default).
- Frame end: an accepted beat with S_LAST=1 latches pending_cycle = index of that beat (count-1) and moves to PENDING.
  - A single-beat frame gives pending_cycle=0.
- S_START during LOAD (with or without a simultaneous beat) restarts the frame.
  - A simultaneous beat is ignored.
  - idx returns to 0 and the state stays LOAD.
- S_START in PENDING is ignored.
- A frame with no beats never commits.
- PENDING: S_READY=0.
  - The first SAMPLER_WRAP=1 seen in PENDING triggers the swap in the next cycle: ACTIVE_BANK toggles, MOD_CYCLE <= pending_cycle, state returns to IDLE.
  - SAMPLER_WRAP asserted in the same cycle as the S_LAST beat is not used; the last BRAM write must complete first.
  - SAMPLER_WRAP outside PENDING is ignored.
- ACTIVE_BANK and MOD_CYCLE change only on a swap and change in the same cycle.
- The sampler wrap compare uses the old MOD_CYCLE up to and including the swap cycle.
- BUSY = (state != IDLE).
- Widths: when ADDR_WIDTH < 16, MOD_CYCLE is zero-extended.

Test Plan:
1. Reset, then START followed by 4 beats 0x10,0x20,0x30,0x40 (last on 0x40) -> BRAM writes at addr 0x10000..0x10003 with those data, each one cycle after its beat; state PENDING; MOD_CYCLE still 0 and ACTIVE_BANK still 0 until a WRAP pulse; the cycle after WRAP: ACTIVE_BANK=1, MOD_CYCLE=3, BUSY=0.
2. Second frame of 2 beats after test 1 -> writes go to bank 0 (addr 0x00000, 0x00001); after WRAP, ACTIVE_BANK=0 and MOD_CYCLE=1.
3. START, 3 beats, START again, then 1 beat with S_LAST and data 0xAA -> single write at idx 0 after the restart; MOD_CYCLE=0 after the swap.
4. Overflow: 65537 beats with S_LAST on the final beat -> 65536 writes, no write for the final beat, ERR_OVERFLOW=1, MOD_CYCLE=0xFFFF after the swap; ERR_OVERFLOW clears on the next START.
5. WRAP in the same cycle as the S_LAST beat -> no swap; the next WRAP swaps. S_VALID held high in PENDING -> S_READY=0 and no writes.
6. RST asserted during LOAD and during PENDING -> all outputs return to reset values the next cycle, no swap occurs, and a following full frame commits correctly to bank 1.
